// File: rtl/branch_pc_unit_pkg.sv
// Shared types and constants for the branch / PC stage.
// Holds funct3 codes, the flush FSM encoding and the JALR target helper.
package rv32_branch_pkg;

  localparam int RV_XLEN = 32;

  typedef logic [RV_XLEN-1:0] word_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic word_t jalr_target(
    input word_t base,
    input word_t off
  );
    word_t sum;
    sum = base + off;
    return {sum[RV_XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Execute-side bundle of the branch / PC stage.
// slave: the PC unit; master: execute stage / comparator driving it.
interface branch_pc_unit_if;
  import rv32_branch_pkg::*;

  logic       stall;
  logic       br_valid;
  logic       is_jal;
  logic       is_jalr;
  logic [2:0] funct3;
  logic       BrEq;
  logic       BrLT;
  word_t      ex_pc;
  word_t      imm;
  word_t      rs1;
  logic       BrUn;
  word_t      pc;
  word_t      link;
  logic       taken;
  logic       flush;
`ifdef MISALIGN_TRAP_EN
  logic       misalign;
`endif

  modport master (
    output stall, br_valid, is_jal, is_jalr,
    output funct3, BrEq, BrLT,
    output ex_pc, imm, rs1,
`ifdef MISALIGN_TRAP_EN
    input  misalign,
`endif
    input  BrUn, pc, link, taken, flush
  );

  modport slave (
    input  stall, br_valid, is_jal, is_jalr,
    input  funct3, BrEq, BrLT,
    input  ex_pc, imm, rs1,
`ifdef MISALIGN_TRAP_EN
    output misalign,
`endif
    output BrUn, pc, link, taken, flush
  );

endinterface

// File: rtl/branch_pc_unit_decide.sv
// Conditional-branch decision from funct3 and comparator flags.
// In: funct3, BrEq, BrLT. Out: cond_taken, BrUn (= funct3[1]).
module branch_decide
  import rv32_branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       cond_taken,
  output logic       BrUn
);

  assign BrUn = funct3[1];

  always_comb begin
    cond_taken = 1'b0;
    unique case (1'b1)
      (funct3 == F3_BEQ):  cond_taken = BrEq;
      (funct3 == F3_BNE):  cond_taken = !BrEq;
      (funct3 == F3_BLT),
      (funct3 == F3_BLTU): cond_taken = BrLT;
      (funct3 == F3_BGE),
      (funct3 == F3_BGEU): cond_taken = !BrLT;
      default:             cond_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register, branch/jump redirect and post-redirect flush sequencer.
// Ports: clk, rst (sync, active-high), bus (branch_pc_unit_if.slave).
// Option MISALIGN_TRAP_EN: misaligned taken targets go to TRAP_VEC
// and raise a one-cycle misalign pulse.
module branch_pc_unit
  import rv32_branch_pkg::*;
#(
  parameter word_t RESET_PC     = 32'h0000_0000,
`ifdef MISALIGN_TRAP_EN
  parameter word_t TRAP_VEC     = 32'h0000_0100,
`endif
  parameter int    FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  branch_pc_unit_if.slave bus
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;
  word_t      pc_q;
  word_t      tgt_raw;
  word_t      tgt;
  logic       cond_taken;
  logic       run;
  logic       req;
  logic       taken_c;

  branch_decide u_decide (
    .funct3     (bus.funct3),
    .BrEq       (bus.BrEq),
    .BrLT       (bus.BrLT),
    .cond_taken (cond_taken),
    .BrUn       (bus.BrUn)
  );

  // Redirects only from RUN; in FLUSH the execute slot is being killed.
  assign run = (state == RUN) && !bus.stall;

  // jalr > jal > branch when more than one is flagged.
  assign req = bus.is_jalr | bus.is_jal
             | (bus.br_valid & cond_taken);

  assign taken_c = run & req;

  assign tgt_raw = bus.is_jalr
                 ? jalr_target(bus.rs1, bus.imm)
                 : bus.ex_pc + bus.imm;

`ifdef MISALIGN_TRAP_EN
  logic bad;
  logic mis_q;

  assign bad = taken_c && (tgt_raw[1:0] != 2'b00);
  assign tgt = bad ? TRAP_VEC : tgt_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= bad;
    end
  end

  assign bus.misalign = mis_q;
`else
  assign tgt = tgt_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (!bus.stall) begin
      pc_q <= taken_c ? tgt : pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN: begin
        if (taken_c) begin
          state_nx = FLUSH;
          cnt_nx   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          if (cnt == 3'd0) begin
            state_nx = RUN;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  // flush is a pure decode of the state register.
  always_comb begin
    bus.flush = (state == FLUSH);
  end

  assign bus.pc    = pc_q;
  assign bus.link  = bus.ex_pc + 32'd4;
  assign bus.taken = taken_c;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: directed cases then random.
// Driver pushes expected per-cycle outputs; negedge monitor compares.
module tb_branch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;
  localparam int          NFL    = 2;

  typedef struct {
    logic [31:0] pc;
    bit          flush;
    bit          taken;
    bit          brun;
    logic [31:0] link;
    bit          mis;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  logic [31:0] pc_m;
  int          fl_m;
  bit          mis_m;

  branch_pc_unit_if bif();

  branch_pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc", bif.pc, e.pc);
      check("flush", 32'(bif.flush), 32'(e.flush));
      check("taken", 32'(bif.taken), 32'(e.taken));
      check("BrUn", 32'(bif.BrUn), 32'(e.brun));
      check("link", bif.link, e.link);
`ifdef MISALIGN_TRAP_EN
      check("misalign", 32'(bif.misalign), 32'(e.mis));
`endif
    end
  end

  // Reference: architectural branch semantics on raw operands.
  function automatic bit br_go(logic [2:0] f3,
                               logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(bit r, bit st, bit bv, bit j, bit jr,
                      logic [2:0] f3,
                      logic [31:0] a, logic [31:0] b,
                      logic [31:0] epc, logic [31:0] im,
                      logic [31:0] r1);
    exp_t        e;
    logic [31:0] tgt;
    bit          tk;
    bit          un;
    bit          mis_now;
    un = f3[1];
    rst          = r;
    bif.stall    = st;
    bif.br_valid = bv;
    bif.is_jal   = j;
    bif.is_jalr  = jr;
    bif.funct3   = f3;
    bif.BrEq     = (a == b);
    bif.BrLT     = un ? (a < b) : ($signed(a) < $signed(b));
    bif.ex_pc    = epc;
    bif.imm      = im;
    bif.rs1      = r1;
    if (jr) tgt = (r1 + im) & 32'hFFFF_FFFE;
    else    tgt = epc + im;
    tk = (fl_m == 0) && !st && (jr || j || (bv && br_go(f3, a, b)));
    mis_now = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (tk && tgt[1:0] != 2'b00) begin
      tgt = TRAP;
      mis_now = 1'b1;
    end
`endif
    e.pc    = pc_m;
    e.flush = (fl_m != 0);
    e.taken = tk;
    e.brun  = un;
    e.link  = epc + 32'd4;
    e.mis   = mis_m;
    q.push_back(e);
    if (r) begin
      pc_m  = RST_PC;
      fl_m  = 0;
      mis_m = 1'b0;
    end else begin
      mis_m = mis_now;
      if (!st) begin
        pc_m = tk ? tgt : pc_m + 32'd4;
        if (tk)            fl_m = NFL;
        else if (fl_m > 0) fl_m = fl_m - 1;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 3'd0, 0, 1, 32'h200, 0, 0);
  endtask

  task automatic stall_n(int n);
    for (int i = 0; i < n; i++)
      step(0, 1, 0, 0, 0, 3'd0, 0, 1, 32'h200, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    pc_m   = RST_PC;
    fl_m   = 0;
    mis_m  = 1'b0;
    rst          = 1'b1;
    bif.stall    = 1'b0;
    bif.br_valid = 1'b0;
    bif.is_jal   = 1'b0;
    bif.is_jalr  = 1'b0;
    bif.funct3   = 3'd0;
    bif.BrEq     = 1'b0;
    bif.BrLT     = 1'b0;
    bif.ex_pc    = 32'd0;
    bif.imm      = 32'd0;
    bif.rs1      = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    idle(4);
    // BEQ taken, then flush window
    step(0, 0, 1, 0, 0, 3'b000, 7, 7, 32'h40, 32'h20, 0);
    idle(4);
    // BGEU equal operands -> taken
    step(0, 0, 1, 0, 0, 3'b111, 9, 9, 32'h80, 32'h10, 0);
    idle(4);
    // BLTU with a > b -> not taken
    step(0, 0, 1, 0, 0, 3'b110, 5, 3, 32'h90, 32'h10, 0);
    idle(1);
    // JALR with odd base
    step(0, 0, 0, 0, 1, 3'b000, 0, 0, 32'h50, 0, 32'h1003);
    idle(4);
    // redirect, stall in FLUSH, ignored branch
    step(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h100, 32'h40, 0);
    stall_n(3);
    step(0, 0, 1, 0, 0, 3'b000, 3, 3, 32'h10, 32'h80, 0);
    idle(3);
    // reset mid-flush
    step(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h300, 32'h40, 0);
    step(1, 0, 0, 0, 0, 3'b000, 0, 1, 32'h0, 0, 0);
    idle(2);
    // PC wrap at the top of the address space
    step(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFF0, 32'hC, 0);
    idle(4);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] im;
      bit r, st, bv, j, jr;
      a  = $urandom_range(0, 3) == 0 ? 32'h55 : $urandom;
      b  = $urandom_range(0, 2) == 0 ? a : $urandom;
      im = $urandom;
      if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
      r  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 4) == 0);
      bv = ($urandom_range(0, 9) < 4);
      j  = ($urandom_range(0, 9) == 0);
      jr = ($urandom_range(0, 9) == 0);
      step(r, st, bv, j, jr, 3'($urandom),
           a, b, $urandom & 32'hFFFF_FFFC, im, $urandom);
    end
    idle(2);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
